rfft_stage_sequencer: RTL and testbench
=======================================

// Module: rfft_stage_sequencer
// PURPOSE
//   Control sequencer for the 4-bank radix RFFT datapath (256 points, 4 x 64-word banks, one pe).
//   On start, runs NUM_STAGES butterfly passes.
//   Per pass it drives bank read/write addresses, bank-swap selects, twiddle address, write enable and bypass_n.
//   Sits between the top-level controller (start/done) and the bram/pe datapath; contains no data path itself.
// PARAMETERS
//   ADDR_W      6   bank address width (64 words per bank)
//   NUM_STAGES  7   butterfly passes; last pass (index NUM_STAGES-1) runs with bypass_n=0
//   PE_LATENCY  2   pe pipeline depth in cycles; total read->write latency LAT = PE_LATENCY+1 (bram read)
// PORTS
//   Clk        in   1       clock, all logic on rising edge
//   Reset      in   1       synchronous, active-high reset
//   start      in   1       request a full transform; sampled only in IDLE
//   busy       out  1       high from the cycle after start is accepted until done
//   done       out  1       one-cycle pulse, transform complete
//   stage      out  3       current pass index 0..NUM_STAGES-1
//   rd_addr0   out  ADDR_W  read address, banks 0/1
//   rd_addr1   out  ADDR_W  read address, banks 2/3
//   in_swap    out  1       1 = pe inputs take banks 2/3 in place of 0/1
//   tf_addr    out  ADDR_W  twiddle ROM address, aligned with rd_addr*
//   wr_addr0   out  ADDR_W  write address, banks 0/1
//   wr_addr1   out  ADDR_W  write address, banks 2/3
//   out_swap   out  1       1 = pe outputs 2/3 route to banks 0/1
//   we         out  1       bank write enable, all four banks
//   bypass_n   out  1       0 during the last pass, else 1
// BEHAVIOUR
//   Reset values: busy=0 done=0 we=0 stage=0 in_swap=0 out_swap=0 bypass_n=1, all addresses 0; FSM=IDLE.
//   FSM IDLE -> READ on start. READ issues 64 reads, cnt 0..63. READ -> DRAIN after cnt=63.
//   DRAIN lasts exactly LAT cycles. Then: if stage<NUM_STAGES-1, stage++ and -> READ; else -> IDLE with done=1.
//   No read of pass s+1 overlaps a write of pass s (RAW safety); each pass is exactly 64+LAT cycles.
//   Read side, registered, pass s, counter cnt:
//     rd_addr0 = cnt
//     rd_addr1 = cnt ^ MASK(s), where MASK(s) = top s bits set (s=0: 6'h00, s=1: 6'h20, ... s=6: 6'h3F)
//     in_swap  = (s!=0) & cnt[ADDR_W-s]
//     tf_addr  = (cnt << s) mod 64
//     out_swap tag = cnt[ADDR_W-1-s] for s<=5, else 0
//   Write side: rd_addr0, rd_addr1 and out_swap tag pass through a LAT-deep delay line together with a valid bit.
//     Delayed values drive wr_addr0, wr_addr1 and out_swap. we = delayed valid.
//     Exactly 64 we pulses per pass.
//   bypass_n = (stage != NUM_STAGES-1). Registered, changes only at pass boundaries.
//   Outside READ: rd_addr*, tf_addr and in_swap hold 0. Outside write-valid: wr_addr* and out_swap hold 0.
//   done asserts in the first IDLE cycle. A start in that same cycle is accepted; busy rises next cycle.
//   start while busy: ignored, not queued.
//   Reset mid-transform: next cycle FSM=IDLE, delay line flushed, we=0, no done pulse.
//   Counters are ADDR_W-bit wrap-free. cnt never exceeds 63; stage never exceeds NUM_STAGES-1.
// STRUCTURE
//   Shared package rfft_pkg holds:
//     ADDR_W, NUM_STAGES, PE_LATENCY defaults
//     FSM state encoding (IDLE, READ, DRAIN)
//     function stage_mask(s) returning MASK(s)
//   Sub-module rfft_wr_delay: LAT-deep shift register of {valid, addr0, addr1, swap}, synchronous flush on Reset.
// TESTING
//   1. Reset, start one cycle:
//      busy=1 next cycle.
//      done pulses exactly 7*(64+3)+1 = 470 cycles after the start cycle.
//      we high for exactly 448 cycles in total.
//   2. Pass 1, cnt=5: rd_addr0=5, rd_addr1=6'h25, in_swap=0, tf_addr=10.
//      Three cycles later: we=1, wr_addr0=5, wr_addr1=6'h25.
//   3. Pass 6, cnt=0x2A: rd_addr1=0x15, in_swap=0, tf_addr=0, bypass_n=0.
//      Passes 0..5: bypass_n=1.
//   4. Pass boundary: the first read of pass s+1 occurs only after the last we of pass s. No cycle has a read
//      and a write of different passes.
//   5. Start pulsed while busy at cycle 100: no effect, single done at cycle 470.
//      Start asserted in the done cycle: second run begins immediately.
//   6. Reset asserted in pass 3, mid-READ: next cycle IDLE, we=0, stage=0, busy=0, no done pulse.
//      Later start runs the full 470-cycle sequence.

Source files
------------

// File: rtl/rfft_pkg.sv
// Shared definitions for the RFFT stage sequencer: sizes, FSM encoding and
// the per-cycle read-side address function.
package rfft_pkg;

    localparam int ADDR_W     = 6;
    localparam int NUM_STAGES = 7;
    localparam int PE_LATENCY = 2;
    localparam int LAT        = PE_LATENCY + 1;
    localparam int STAGE_W    = 3;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } seq_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr0;
        logic [ADDR_W-1:0] addr1;
        logic [ADDR_W-1:0] tf;
        logic              in_swap;
        logic              tag;
    } rd_fields_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr0;
        logic [ADDR_W-1:0] addr1;
        logic              swap;
    } wr_slot_t;

    // Top s bits set: the butterfly partner distance shrinks by half each pass.
    function automatic logic [ADDR_W-1:0] stage_mask(input logic [STAGE_W-1:0] s);
        logic [ADDR_W-1:0] m;
        m = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            if (i >= ADDR_W - int'(s)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic rd_fields_t read_fields(input logic [ADDR_W-1:0] cnt,
                                               input logic [STAGE_W-1:0] s);
        rd_fields_t        f;
        logic [ADDR_W-1:0] sh;
        f.addr0   = cnt;
        f.addr1   = cnt ^ stage_mask(s);
        f.tf      = cnt << s;
        sh        = cnt >> (ADDR_W - int'(s));
        f.in_swap = (s != '0) && sh[0];
        f.tag     = 1'b0;
        if (int'(s) < ADDR_W) begin
            sh    = cnt >> (ADDR_W - 1 - int'(s));
            f.tag = sh[0];
        end
        return f;
    endfunction

endpackage

// File: rtl/rfft_wr_delay.sv
// Write-side delay line: carries read addresses and the output-swap tag forward
// by the bram+pe latency so writes land on the matching results.
module rfft_wr_delay
    import rfft_pkg::*;
#(
    parameter int DEPTH = LAT
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr0,
    input  logic [ADDR_W-1:0] in_addr1,
    input  logic              in_swap,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr0,
    output logic [ADDR_W-1:0] out_addr1,
    output logic              out_swap
);

    wr_slot_t line [DEPTH];

    // Invalid slots carry zeros so the write outputs rest at 0 between bursts.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                line[i] <= '0;
            end
        end else begin
            line[0] <= in_valid ? '{valid: 1'b1, addr0: in_addr0, addr1: in_addr1, swap: in_swap}
                                : '0;
            for (int i = 1; i < DEPTH; i++) begin
                line[i] <= line[i-1];
            end
        end
    end

    assign out_valid = line[DEPTH-1].valid;
    assign out_addr0 = line[DEPTH-1].addr0;
    assign out_addr1 = line[DEPTH-1].addr1;
    assign out_swap  = line[DEPTH-1].swap;

endmodule

// File: rtl/rfft_stage_sequencer.sv
// Pass sequencer for the 4-bank RFFT: walks NUM_STAGES butterfly passes, each a
// 64-read burst followed by a drain so no pass reads data still in flight.
module rfft_stage_sequencer
    import rfft_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [STAGE_W-1:0] stage,
    output logic [ADDR_W-1:0]  rd_addr0,
    output logic [ADDR_W-1:0]  rd_addr1,
    output logic               in_swap,
    output logic [ADDR_W-1:0]  tf_addr,
    output logic [ADDR_W-1:0]  wr_addr0,
    output logic [ADDR_W-1:0]  wr_addr1,
    output logic               out_swap,
    output logic               we,
    output logic               bypass_n
);

    localparam int                 DRAIN_W    = $clog2(LAT + 1);
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);
    localparam logic [STAGE_W-1:0] PENULT     = STAGE_W'(NUM_STAGES - 2);

    seq_state_t          state;
    logic [ADDR_W-1:0]   cnt;
    logic [DRAIN_W-1:0]  drain_cnt;
    rd_fields_t          rd;

    // Read-side fields are registered for the cycle they are presented, so
    // each transition loads the values belonging to the next counter value.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            drain_cnt <= '0;
            stage     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bypass_n  <= 1'b1;
            rd        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= READ;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        stage    <= '0;
                        bypass_n <= (LAST_STAGE != '0);
                        rd       <= read_fields('0, '0);
                    end
                end
                READ: begin
                    if (cnt == '1) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                        rd        <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        rd  <= read_fields(cnt + 1'b1, stage);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_W'(LAT - 1)) begin
                        if (stage == LAST_STAGE) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            stage    <= '0;
                            bypass_n <= 1'b1;
                        end else begin
                            state    <= READ;
                            stage    <= stage + 1'b1;
                            bypass_n <= (stage != PENULT);
                            cnt      <= '0;
                            rd       <= read_fields('0, stage + 1'b1);
                        end
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rd_addr0 = rd.addr0;
    assign rd_addr1 = rd.addr1;
    assign tf_addr  = rd.tf;
    assign in_swap  = rd.in_swap;

    rfft_wr_delay #(
        .DEPTH (LAT)
    ) u_wr_delay (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (state == READ),
        .in_addr0  (rd.addr0),
        .in_addr1  (rd.addr1),
        .in_swap   (rd.tag),
        .out_valid (we),
        .out_addr0 (wr_addr0),
        .out_addr1 (wr_addr1),
        .out_swap  (out_swap)
    );

endmodule

// File: tb/tb_rfft_stage_sequencer.sv
// Scoreboard bench for rfft_stage_sequencer: the driver pushes the expected
// transform position for every cycle, the monitor checks all outputs from it.
module tb_rfft_stage_sequencer;

    localparam int PASS_LEN = 64 + 3;
    localparam int STAGES   = 7;
    localparam int DONE_K   = STAGES * PASS_LEN + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       busy, done, in_swap, out_swap, we, bypass_n;
    logic [2:0] stage;
    logic [5:0] rd_addr0, rd_addr1, tf_addr, wr_addr0, wr_addr1;

    typedef struct {
        int busy;
        int done;
        int stage;
        int rd0;
        int rd1;
        int in_swap;
        int tf;
        int wr0;
        int wr1;
        int out_swap;
        int we;
        int bypass_n;
    } obs_t;

    typedef struct {
        int cyc;
        int k;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc       = 0;
    int   cur_k     = -1;
    int   total     = 0;
    int   bad       = 0;
    int   we_seen   = 0;
    int   we_want   = 0;
    int   done_seen = 0;
    int   done_want = 0;

    rfft_stage_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .stage    (stage),
        .rd_addr0 (rd_addr0),
        .rd_addr1 (rd_addr1),
        .in_swap  (in_swap),
        .tf_addr  (tf_addr),
        .wr_addr0 (wr_addr0),
        .wr_addr1 (wr_addr1),
        .out_swap (out_swap),
        .we       (we),
        .bypass_n (bypass_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // k = cycles since the accepted start (1..469 busy, 470 done), -1 idle.
    function automatic obs_t model_out(input int k);
        obs_t o;
        int   s, off, c, m;
        o = '{default: 0};
        o.bypass_n = 1;
        if (k == DONE_K) o.done = 1;
        if (k >= 1 && k < DONE_K) begin
            s   = (k - 1) / PASS_LEN;
            off = (k - 1) % PASS_LEN;
            m   = 64 - (64 >> s);
            o.busy     = 1;
            o.stage    = s;
            o.bypass_n = (s != STAGES - 1) ? 1 : 0;
            if (off < 64) begin
                o.rd0     = off;
                o.rd1     = off ^ m;
                o.in_swap = (s != 0 && ((off >> (6 - s)) & 1) != 0) ? 1 : 0;
                o.tf      = (off << s) % 64;
            end
            if (off >= 3) begin
                c          = off - 3;
                o.we       = 1;
                o.wr0      = c;
                o.wr1      = c ^ m;
                o.out_swap = (s <= 5 && ((c >> (5 - s)) & 1) != 0) ? 1 : 0;
            end
        end
        return o;
    endfunction

    task automatic check_field(input string name, input int got, input int want, input int k);
        total++;
        if (got != want) begin
            bad++;
            $display("[TB] FAIL %s cyc=%0d k=%0d got=%0d want=%0d", name, cyc, k, got, want);
        end
    endtask

    task automatic check_output(input int k);
        obs_t w, a;
        w = model_out(k);
        a.busy = int'(busy);     a.done = int'(done);         a.stage = int'(stage);
        a.rd0 = int'(rd_addr0);  a.rd1 = int'(rd_addr1);      a.in_swap = int'(in_swap);
        a.tf = int'(tf_addr);    a.wr0 = int'(wr_addr0);      a.wr1 = int'(wr_addr1);
        a.out_swap = int'(out_swap); a.we = int'(we);         a.bypass_n = int'(bypass_n);
        check_field("busy", a.busy, w.busy, k);
        check_field("done", a.done, w.done, k);
        check_field("stage", a.stage, w.stage, k);
        check_field("rd_addr0", a.rd0, w.rd0, k);
        check_field("rd_addr1", a.rd1, w.rd1, k);
        check_field("in_swap", a.in_swap, w.in_swap, k);
        check_field("tf_addr", a.tf, w.tf, k);
        check_field("wr_addr0", a.wr0, w.wr0, k);
        check_field("wr_addr1", a.wr1, w.wr1, k);
        check_field("out_swap", a.out_swap, w.out_swap, k);
        check_field("we", a.we, w.we, k);
        check_field("bypass_n", a.bypass_n, w.bypass_n, k);
        we_seen   += a.we;
        we_want   += w.we;
        done_seen += a.done;
        done_want += w.done;
    endtask

    // Drives one cycle's inputs and queues the transform position of the next cycle.
    task automatic apply_stimulus(input logic r, input logic s);
        int nk;
        @(posedge clk);
        #1;
        reset = r;
        start = s;
        if (r) nk = -1;
        else if (cur_k >= 1 && cur_k < DONE_K) nk = cur_k + 1;
        else nk = s ? 1 : -1;
        exp_q.push_back('{cyc: cyc + 1, k: nk});
        cur_k = nk;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            mon_e = exp_q.pop_front();
            check_output(mon_e.k);
        end
    end

    initial begin
        int gap, rst_at, guard;
        reset = 1'b1;
        start = 1'b0;
        exp_q.push_back('{cyc: 1, k: -1});
        repeat (3) apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0);

        // Full run with a stray start at cycle 100, then a back-to-back start in the done cycle.
        apply_stimulus(1'b0, 1'b1);
        for (int i = 1; i <= DONE_K; i++) apply_stimulus(1'b0, (i == 100 || i == DONE_K));
        for (int i = 1; i <= DONE_K; i++) apply_stimulus(1'b0, 1'b0);

        // Reset in the middle of pass 3's read burst, then a clean full run.
        apply_stimulus(1'b0, 1'b1);
        while (cur_k < 3 * PASS_LEN + 21) apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0);
        repeat (2) apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b1);
        guard = 0;
        while (cur_k != -1 && guard < 1000) begin
            apply_stimulus(1'b0, 1'b0);
            guard++;
        end

        for (int r = 0; r < 5; r++) begin
            gap    = $urandom_range(0, 4);
            rst_at = ($urandom_range(0, 2) == 0) ? $urandom_range(1, DONE_K - 1) : -1;
            repeat (gap) apply_stimulus(1'b0, 1'b0);
            apply_stimulus(1'b0, 1'b1);
            guard = 0;
            while (cur_k != -1 && cur_k != DONE_K && guard < 1000) begin
                apply_stimulus(cur_k == rst_at, $urandom_range(0, 15) == 0);
                guard++;
            end
            if (cur_k == DONE_K) apply_stimulus(1'b0, $urandom_range(0, 1) == 1);
        end

        guard = 0;
        while (cur_k != -1 && guard < 1000) begin
            apply_stimulus(1'b0, 1'b0);
            guard++;
        end
        repeat (3) apply_stimulus(1'b0, 1'b0);
        @(negedge clk);
        #1;

        total++;
        if (exp_q.size() > 1) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain left=%0d allowed=1", exp_q.size());
        end
        total++;
        if (we_seen != we_want) begin
            bad++;
            $display("[TB] FAIL we_total got=%0d want=%0d", we_seen, we_want);
        end
        total++;
        if (done_seen != done_want) begin
            bad++;
            $display("[TB] FAIL done_total got=%0d want=%0d", done_seen, done_want);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
